// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// taken-branch flushes, data-memory freeze, plus stall/flush statistics.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MAX_WAIT          = 64,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic             branch_taken_mem,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             wait_timeout
);

  localparam int unsigned REM_W  = 4;
  localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd2;

  logic [1:0]        state_q, state_d, eff_state;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              timeout_q, timeout_d;
  logic              hazard;

  assign hazard = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                  ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  assign stall_count  = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
  assign wait_timeout = timeout_q;

  // Leaving MEM_WAIT behaves exactly like the state being returned to.
  always_comb begin
    eff_state = state_q;
    if ((state_q == ST_MEM_WAIT) && !mem_busy) begin
      eff_state = (rem_q != '0) ? ST_LOAD_STALL : ST_RUN;
    end
  end

  // Next-state, pipeline control outputs and counter updates.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    wcnt_d       = wcnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    timeout_d    = timeout_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_flush = 1'b0;

    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      state_d     = ST_MEM_WAIT;
      if (wcnt_q == WCNT_W'(MAX_WAIT)) begin
        timeout_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + WCNT_W'(1);
      end
    end else begin
      wcnt_d = '0;
      if (branch_taken_mem) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_flush = 1'b1;
        rem_d        = '0;
        state_d      = ST_RUN;
        if (flush_cnt_q != '1) begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end else if (eff_state == ST_LOAD_STALL) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        rem_d        = rem_q - REM_W'(1);
        state_d      = (rem_q == REM_W'(1)) ? ST_RUN : ST_LOAD_STALL;
      end else if (hazard) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          rem_d   = REM_W'(LOAD_STALL_CYCLES - 1);
          state_d = ST_LOAD_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        state_d = ST_RUN;
      end
    end

    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State and statistics registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      rem_q       <= '0;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (1-cycle and 3-cycle load
// stall, 16- and 4-bit counters) share stimulus; a reference model pushes
// expected outputs per cycle into a scoreboard that is drained on sampling.
module tb_pipeline_hazard_ctrl;

  localparam int M_RUN = 0;
  localparam int M_LS  = 1;
  localparam int M_MW  = 2;
  localparam int MAXW  = 64;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [15:0] sc;
    logic [15:0] fc;
    logic        to;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic       if_id_uses_rt, id_ex_mem_read, branch_taken_mem, mem_busy;

  logic        a_pc, a_ifw, a_idw, a_iff, a_bub, a_emf, a_to;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_ifw, b_idw, b_iff, b_bub, b_emf, b_to;
  logic [3:0]  b_sc, b_fc;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  int m_st[2], m_rem[2], m_wcnt[2], m_sc[2], m_fc[2];
  bit m_to[2];

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MAX_WAIT(64), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .branch_taken_mem(branch_taken_mem), .mem_busy(mem_busy),
    .pc_write(a_pc), .if_id_write(a_ifw), .id_ex_write(a_idw), .if_id_flush(a_iff),
    .id_ex_bubble(a_bub), .ex_mem_flush(a_emf), .stall_count(a_sc), .flush_count(a_fc),
    .wait_timeout(a_to)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MAX_WAIT(64), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_uses_rt(if_id_uses_rt), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .branch_taken_mem(branch_taken_mem), .mem_busy(mem_busy),
    .pc_write(b_pc), .if_id_write(b_ifw), .id_ex_write(b_idw), .if_id_flush(b_iff),
    .id_ex_bubble(b_bub), .ex_mem_flush(b_emf), .stall_count(b_sc), .flush_count(b_fc),
    .wait_timeout(b_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for one clock cycle; returns outputs seen before the edge.
  task automatic model_cycle(input int k, output exp_t e);
    bit hz;
    int lsc, cmax, st;
    lsc  = (k == 0) ? 1 : 3;
    cmax = (k == 0) ? 65535 : 15;
    e.sc = 16'(m_sc[k]);
    e.fc = 16'(m_fc[k]);
    e.to = m_to[k];
    hz = id_ex_mem_read && (id_ex_rt != 5'd0) &&
         ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    if (!reset) begin
      e.ctrl = 6'b000111;
      m_st[k] = M_RUN; m_rem[k] = 0; m_wcnt[k] = 0;
      m_sc[k] = 0; m_fc[k] = 0; m_to[k] = 1'b0;
    end else begin
      if (mem_busy) begin
        e.ctrl = 6'b000000;
        if (m_wcnt[k] == MAXW) m_to[k] = 1'b1;
        else m_wcnt[k]++;
        m_st[k] = M_MW;
      end else begin
        st = m_st[k];
        m_wcnt[k] = 0;
        if (st == M_MW) st = (m_rem[k] > 0) ? M_LS : M_RUN;
        if (branch_taken_mem) begin
          e.ctrl = 6'b111111;
          m_rem[k] = 0;
          m_st[k] = M_RUN;
          if (m_fc[k] < cmax) m_fc[k]++;
        end else if (st == M_LS) begin
          e.ctrl = 6'b001010;
          m_rem[k]--;
          m_st[k] = (m_rem[k] == 0) ? M_RUN : M_LS;
        end else if (hz) begin
          e.ctrl = 6'b001010;
          if (lsc > 1) begin
            m_st[k] = M_LS;
            m_rem[k] = lsc - 1;
          end else begin
            m_st[k] = M_RUN;
          end
        end else begin
          e.ctrl = 6'b111000;
          m_st[k] = M_RUN;
        end
      end
      if (!e.ctrl[5] && (m_sc[k] < cmax)) m_sc[k]++;
    end
  endtask

  // Push expectations for this cycle, sample both DUTs, then advance a clock.
  task automatic tick();
    exp_t e;
    model_cycle(0, e);
    sb_q.push_back(e);
    model_cycle(1, e);
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check("a_ctrl", 32'({a_pc, a_ifw, a_idw, a_iff, a_bub, a_emf}), 32'(e.ctrl));
    check("a_stall_count", 32'(a_sc), 32'(e.sc));
    check("a_flush_count", 32'(a_fc), 32'(e.fc));
    check("a_wait_timeout", 32'(a_to), 32'(e.to));
    e = sb_q.pop_front();
    check("b_ctrl", 32'({b_pc, b_ifw, b_idw, b_iff, b_bub, b_emf}), 32'(e.ctrl));
    check("b_stall_count", 32'(b_sc), 32'(e.sc));
    check("b_flush_count", 32'(b_fc), 32'(e.fc));
    check("b_wait_timeout", 32'(b_to), 32'(e.to));
    @(negedge clk);
  endtask

  task automatic drive(input bit rst, input bit mr, input logic [4:0] exrt,
                       input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                       input bit br, input bit busy);
    reset = rst; id_ex_mem_read = mr; id_ex_rt = exrt; if_id_rs = rs;
    if_id_rt = rt; if_id_uses_rt = urt; branch_taken_mem = br; mem_busy = busy;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  // lw $2 in ID/EX with add $3,$2,$4 in IF/ID.
  task automatic lw_use();
    drive(1, 1, 5'd2, 5'd2, 5'd4, 1, 0, 0);
  endtask

  initial begin
    reset = 1'b0; id_ex_mem_read = 1'b0; id_ex_rt = '0; if_id_rs = '0;
    if_id_rt = '0; if_id_uses_rt = 1'b0; branch_taken_mem = 1'b0; mem_busy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_RUN; m_rem[k] = 0; m_wcnt[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_to[k] = 0;
    end
    @(negedge clk);

    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    check("reset_a_stall_count", 32'(a_sc), 32'd0);
    check("reset_b_flush_count", 32'(b_fc), 32'd0);
    idle(2);

    lw_use();
    idle(4);
    check("lw_use_a_stall_count", 32'(a_sc), 32'd1);
    check("lw_use_b_stall_count", 32'(b_sc), 32'd3);

    drive(1, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0);
    drive(1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    drive(1, 0, 5'd7, 5'd7, 5'd7, 1, 0, 0);
    check("no_hazard_a_pc_write", 32'(a_pc), 32'd1);
    idle(1);
    check("no_hazard_a_stall_count", 32'(a_sc), 32'd1);

    lw_use();
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    idle(2);
    check("branch_a_flush_count", 32'(a_fc), 32'd1);
    check("branch_b_flush_count", 32'(b_fc), 32'd1);
    check("branch_b_stall_count", 32'(b_sc), 32'd4);

    lw_use();
    for (int i = 0; i < 3; i++) drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    idle(4);
    check("busy_mid_stall_b_stall_count", 32'(b_sc), 32'd10);
    check("busy_mid_stall_a_stall_count", 32'(a_sc), 32'd6);

    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    drive(1, 1, 5'd2, 5'd2, 5'd4, 1, 0, 1);
    idle(2);
    check("busy_over_branch_a_flush_count", 32'(a_fc), 32'd1);

    for (int i = 0; i < 60; i++) drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    check("wait_60_a_timeout", 32'(a_to), 32'd0);
    for (int i = 0; i < 10; i++) drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    check("wait_70_a_timeout", 32'(a_to), 32'd1);
    idle(3);
    check("wait_sticky_a_timeout", 32'(a_to), 32'd1);
    check("wait_sticky_b_timeout", 32'(b_to), 32'd1);

    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    check("reset_clears_timeout", 32'(a_to), 32'd0);
    for (int i = 0; i < 20; i++) lw_use();
    check("sat_b_stall_count", 32'(b_sc), 32'd15);
    check("sat_a_stall_count", 32'(a_sc), 32'd20);
    idle(3);

    for (int i = 0; i < 5; i++) drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    drive(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    check("reset_mid_wait_a_stall_count", 32'(a_sc), 32'd0);
    check("reset_mid_wait_b_stall_count", 32'(b_sc), 32'd0);
    idle(2);

    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
